// File: rtl/avg_level_monitor.sv
// Level alarm on the averaged sample stream: hysteresis thresholds with a
// debounce run count, rise/fall pulses, running peaks and a saturating sample count.
module avg_level_monitor #(
  parameter int DW       = 8,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rs,
  input  logic [DW-1:0]    ave_in,
  input  logic             ave_valid,
  input  logic [DW-1:0]    thr_hi,
  input  logic [DW-1:0]    thr_lo,
  input  logic             clr_peak,
  output logic             alarm,
  output logic             alarm_rise,
  output logic             alarm_fall,
  output logic [DW-1:0]    peak_max,
  output logic [DW-1:0]    peak_min,
  output logic [CNT_W-1:0] sample_cnt,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    S_NORMAL,
    S_ARMING,
    S_ALARM,
    S_CLEARING
  } state_t;

  localparam logic [3:0] DEB = 4'(DEBOUNCE);

  state_t           r_state, w_state_nx;
  logic [3:0]       r_cnt, w_cnt_nx, w_cnt_inc;
  logic             r_alarm, r_rise, r_fall, r_cfg_err;
  logic [DW-1:0]    r_pmax, r_pmin, w_pmax_nx, w_pmin_nx;
  logic [CNT_W-1:0] r_scnt, w_scnt_nx;
  logic             w_above, w_below, w_alarm_nx;

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_above    = ave_in > thr_hi;
    w_below    = ave_in < thr_lo;
    w_cnt_inc  = r_cnt + 4'd1;
    if (r_cfg_err) begin
      w_state_nx = S_NORMAL;
      w_cnt_nx   = '0;
    end else if (ave_valid) begin
      case (r_state)
        S_NORMAL: begin
          // counter is zero here, so w_cnt_inc is the first qualifying sample
          if (w_above) begin
            if (w_cnt_inc == DEB) begin
              w_state_nx = S_ALARM;
              w_cnt_nx   = '0;
            end else begin
              w_state_nx = S_ARMING;
              w_cnt_nx   = w_cnt_inc;
            end
          end
        end
        S_ARMING: begin
          if (!w_above) begin
            w_state_nx = S_NORMAL;
            w_cnt_nx   = '0;
          end else if (w_cnt_inc == DEB) begin
            w_state_nx = S_ALARM;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx   = w_cnt_inc;
          end
        end
        S_ALARM: begin
          if (w_below) begin
            if (w_cnt_inc == DEB) begin
              w_state_nx = S_NORMAL;
              w_cnt_nx   = '0;
            end else begin
              w_state_nx = S_CLEARING;
              w_cnt_nx   = w_cnt_inc;
            end
          end
        end
        S_CLEARING: begin
          if (!w_below) begin
            w_state_nx = S_ALARM;
            w_cnt_nx   = '0;
          end else if (w_cnt_inc == DEB) begin
            w_state_nx = S_NORMAL;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx   = w_cnt_inc;
          end
        end
        default: begin
          w_state_nx = S_NORMAL;
          w_cnt_nx   = '0;
        end
      endcase
    end
    w_alarm_nx = (w_state_nx == S_ALARM) || (w_state_nx == S_CLEARING);
  end

  always_comb begin
    w_pmax_nx = r_pmax;
    w_pmin_nx = r_pmin;
    w_scnt_nx = r_scnt;
    if (ave_valid) begin
      if (clr_peak) begin
        w_pmax_nx = ave_in;
        w_pmin_nx = ave_in;
      end else begin
        if (ave_in > r_pmax) w_pmax_nx = ave_in;
        if (ave_in < r_pmin) w_pmin_nx = ave_in;
      end
      if (r_scnt != '1) w_scnt_nx = r_scnt + 1'b1;
    end else if (clr_peak) begin
      w_pmax_nx = '0;
      w_pmin_nx = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rs) begin
      r_state   <= S_NORMAL;
      r_cnt     <= '0;
      r_alarm   <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_pmax    <= '0;
      r_pmin    <= '1;
      r_scnt    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_alarm   <= w_alarm_nx;
      r_rise    <= w_alarm_nx & ~r_alarm;
      r_fall    <= ~w_alarm_nx & r_alarm;
      r_pmax    <= w_pmax_nx;
      r_pmin    <= w_pmin_nx;
      r_scnt    <= w_scnt_nx;
      r_cfg_err <= (thr_lo >= thr_hi);
    end
  end

  assign alarm      = r_alarm;
  assign alarm_rise = r_rise;
  assign alarm_fall = r_fall;
  assign peak_max   = r_pmax;
  assign peak_min   = r_pmin;
  assign sample_cnt = r_scnt;
  assign cfg_err    = r_cfg_err;

endmodule

// File: doc/avg_level_monitor.md
Name: avg_level_monitor

Overview:
Downstream consumer of the 8-sample moving-average stage (ave8 output). Watches the averaged stream against programmable high/low thresholds, with hysteresis and a debounce count. Raises a registered level alarm with one-cycle rise/fall pulses. Also tracks running peak max/min and a saturating valid-sample count for status readback.

Parameters:
DW, 8, width of averaged sample and thresholds
DEBOUNCE, 4, consecutive qualifying valid samples needed to enter/leave alarm; legal range 1..15
CNT_W, 16, width of sample counter

Ports:
clk  in  1  system clock, all state on rising edge
rs  in  1  reset, synchronous, active-high
ave_in  in  DW  averaged sample from averager (ave8)
ave_valid  in  1  ave_in qualifier; tie 1 when averager updates every clock
thr_hi  in  DW  alarm-enter threshold
thr_lo  in  DW  alarm-exit threshold
clr_peak  in  1  reinitialise peak_max/peak_min
alarm  out  1  registered alarm level
alarm_rise  out  1  one-cycle pulse, first cycle alarm=1
alarm_fall  out  1  one-cycle pulse, first cycle alarm=0 after alarm
peak_max  out  DW  largest valid sample since reset/clear
peak_min  out  DW  smallest valid sample since reset/clear
sample_cnt  out  CNT_W  valid samples accepted, saturating
cfg_err  out  1  registered: thr_lo >= thr_hi

Behaviour:
- Reset (rs=1 at edge, overrides all): state NORMAL, debounce cnt=0, alarm=0, alarm_rise=0, alarm_fall=0, peak_max=0, peak_min=all-ones (255), sample_cnt=0, cfg_err=0.
- Comparisons are unsigned and strict: above = ave_in > thr_hi; below = ave_in < thr_lo.
- FSM states: NORMAL, ARMING, ALARM, CLEARING. Debounce cnt is 4 bits.
- Cycles with ave_valid=0 are ignored: state, cnt, peaks and sample_cnt hold. Gaps do not break a run.
- NORMAL: valid and above -> ARMING, cnt=1; if DEBOUNCE=1, go straight to ALARM.
- ARMING: valid and above -> cnt+1; on reaching DEBOUNCE -> ALARM. Valid and not above -> NORMAL, cnt=0.
- ALARM: valid and below -> CLEARING, cnt=1; if DEBOUNCE=1, go straight to NORMAL.
- CLEARING: valid and below -> cnt+1; on reaching DEBOUNCE -> NORMAL. Valid and not below -> ALARM, cnt=0.
- alarm=1 exactly in ALARM and CLEARING.
- Latency: alarm changes on the same edge that samples the DEBOUNCE-th qualifying input. alarm_rise/alarm_fall are high for exactly that following cycle only.
- cfg_err is registered each cycle from thr_lo >= thr_hi. While cfg_err=1:
  - FSM is forced to NORMAL with cnt=0.
  - If alarm was 1, it drops with an alarm_fall pulse.
  - Peaks and count continue to update.
- Peaks, on valid samples: peak_max = max(peak_max, ave_in); peak_min = min(peak_min, ave_in).
- clr_peak=1:
  - with ave_valid=1: peak_max = peak_min = ave_in.
  - with ave_valid=0: peak_max=0, peak_min=255.
  - Does not affect the FSM or sample_cnt.
- sample_cnt increments per valid sample and saturates at 2^CNT_W-1 (no wrap).
- Reset mid-ALARM: alarm goes to 0 with no alarm_fall pulse.
- Threshold changes take effect on the next valid sample; the debounce cnt is not reset.

Test Plan:
1. Reset with DEBOUNCE=4, thr_hi=150, thr_lo=50 -> all outputs at reset values (peak_min=255). cfg_err=0 after one clock.
2. Valid 200,200,200,200 -> alarm=1 and alarm_rise=1 for one cycle after the 4th edge. 200,200,200,100,200,200,200,200 -> no alarm until the 4th 200 after the 100.
3. In ALARM, feed 20,20,20,100,20,20,20,20 -> alarm stays 1 through the 100. alarm_fall pulses after the 4th consecutive 20. Then 100 -> stays NORMAL.
4. Valid gaps: 200, ave_valid=0 for 5 clocks with ave_in=0, then 200,200,200 -> alarm rises after the 4th valid 200. sample_cnt=4.
5. Peaks: 100,20,55,80,255 -> peak_max=255, peak_min=20. clr_peak with valid 91 -> both 91. clr_peak with ave_valid=0 -> 0/255. Preload sample_cnt near max -> it saturates at 65535.
6. In ALARM, set thr_lo=150, thr_hi=50 -> cfg_err=1, alarm=0 with alarm_fall pulse. Restore thresholds and drive rs=1 mid-ARMING -> state NORMAL, outputs at reset values.
